// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int W_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MULTU = 3'd0,
    OP_MULT  = 3'd1,
    OP_DIVU  = 3'd2,
    OP_DIV   = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the datapath controller and the multiply/divide unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int W = W_DEFAULT
);

  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_core.sv
// One radix-2 iteration: shift-add for multiply, restoring trial subtract for divide.
module muldiv_core #(
  parameter int W = 32
) (
  input  logic         is_div,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] mq,
  input  logic [W-1:0] opnd,
  output logic [W-1:0] acc_next,
  output logic [W-1:0] mq_next
);

  logic [W:0] sum;
  logic [W:0] shifted;
  logic       fits;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum      = '0;
    shifted  = '0;
    fits     = 1'b0;
    acc_next = acc;
    mq_next  = mq;
    if (is_div) begin
      // Remainder stays below the divisor, so the difference always fits in W bits.
      shifted  = {acc, mq[W-1]};
      fits     = shifted >= {1'b0, opnd};
      acc_next = fits ? (shifted[W-1:0] - opnd) : shifted[W-1:0];
      mq_next  = {mq[W-2:0], fits};
    end else begin
      sum      = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : {(W+1){1'b0}});
      acc_next = sum[W:1];
      mq_next  = {sum[0], mq[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV unit with architectural HI/LO; one bit per cycle, flushable.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int W  = W_DEFAULT,
  localparam int CW = $clog2(W) + 1
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  state_e         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   acc, mq, opnd;
  logic [W-1:0]   acc_next, mq_next;
  logic [W-1:0]   hi, lo;
  logic           busy, done, div_by_zero;
  logic           fix_mul, neg_q, neg_r;

  logic           signed_op, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  always_comb begin
    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_neg     = signed_op && bus.a[W-1];
    b_neg     = signed_op && bus.b[W-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
    prod_fix  = neg_q ? -{acc, mq} : {acc, mq};
    quo_fix   = neg_q ? -mq : mq;
    rem_fix   = neg_r ? -acc : acc;
  end

  muldiv_core #(.W(W)) u_core (
    .is_div   (state == DIV),
    .acc      (acc),
    .mq       (mq),
    .opnd     (opnd),
    .acc_next (acc_next),
    .mq_next  (mq_next)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath scratch registers are reset alongside HI/LO so a reset mid-operation leaves nothing stale.
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      mq          <= '0;
      opnd        <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      fix_mul     <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (bus.start) begin
            case (bus.op)
              OP_MULTU, OP_MULT: begin
                state   <= MUL;
                busy    <= 1'b1;
                cnt     <= CW'(W);
                acc     <= '0;
                mq      <= b_mag;
                opnd    <= a_mag;
                fix_mul <= 1'b1;
                neg_q   <= a_neg ^ b_neg;
                neg_r   <= 1'b0;
              end
              OP_DIVU, OP_DIV: begin
                if (bus.b == '0) begin
                  state       <= DONE;
                  done        <= 1'b1;
                  div_by_zero <= 1'b1;
                end else begin
                  state   <= DIV;
                  busy    <= 1'b1;
                  cnt     <= CW'(W);
                  acc     <= '0;
                  mq      <= a_mag;
                  opnd    <= b_mag;
                  fix_mul <= 1'b0;
                  neg_q   <= a_neg ^ b_neg;
                  neg_r   <= a_neg;
                end
              end
              OP_MTHI: begin
                hi    <= bus.a;
                state <= DONE;
                done  <= 1'b1;
              end
              OP_MTLO: begin
                lo    <= bus.a;
                state <= DONE;
                done  <= 1'b1;
              end
              default: begin
                state <= DONE;
                done  <= 1'b1;
              end
            endcase
          end
        end
        MUL, DIV: begin
          acc <= acc_next;
          mq  <= mq_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (fix_mul) begin
            hi <= prod_fix[2*W-1:W];
            lo <= prod_fix[W-1:0];
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.div_by_zero = div_by_zero;
  assign bus.hi          = hi;
  assign bus.lo          = lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at W=32 and W=8 against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    int          sel;
    int          acc;
    int          due;
    int          cancel;
    bit          multi;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
  } exp_t;

  localparam int NEVER = 32'h7FFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t        q[$];
  logic [31:0] pred_hi [2];
  logic [31:0] pred_lo [2];
  int          rd [2];
  logic [31:0] chi [2];
  logic [31:0] clo [2];

  muldiv_if #(.W(32)) bus32 ();
  muldiv_if #(.W(8))  bus8 ();

  muldiv_unit #(.W(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  muldiv_unit #(.W(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_hi(input int s);
    return (s == 0) ? bus32.hi : {24'h0, bus8.hi};
  endfunction
  function automatic logic [31:0] get_lo(input int s);
    return (s == 0) ? bus32.lo : {24'h0, bus8.lo};
  endfunction
  function automatic logic get_busy(input int s);
    return (s == 0) ? bus32.busy : bus8.busy;
  endfunction
  function automatic logic get_done(input int s);
    return (s == 0) ? bus32.done : bus8.done;
  endfunction
  function automatic logic get_dbz(input int s);
    return (s == 0) ? bus32.div_by_zero : bus8.div_by_zero;
  endfunction

  // Reference: plain signed/unsigned arithmetic on sign-extended integers.
  function automatic void model(input int w, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] hi0, input logic [31:0] lo0,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dbz, output int lat);
    longint      sa, sb, qq, rr;
    logic [63:0] p, m;
    bit          sg;
    m   = (64'd1 << w) - 64'd1;
    sg  = (op == OP_MULT) || (op == OP_DIV);
    sa  = longint'({32'h0, a});
    sb  = longint'({32'h0, b});
    if (sg && a[w-1]) sa = sa - (longint'(1) << w);
    if (sg && b[w-1]) sb = sb - (longint'(1) << w);
    hi  = hi0;
    lo  = lo0;
    dbz = 1'b0;
    lat = 1;
    case (op)
      OP_MULTU, OP_MULT: begin
        p   = 64'(sa * sb);
        lo  = 32'(p & m);
        hi  = 32'((p >> w) & m);
        lat = w + 2;
      end
      OP_DIVU, OP_DIV: begin
        if (sb == 0) begin
          dbz = 1'b1;
        end else begin
          qq  = sa / sb;
          rr  = sa % sb;
          lo  = 32'(64'(qq) & m);
          hi  = 32'(64'(rr) & m);
          lat = w + 2;
        end
      end
      OP_MTHI: hi = 32'({32'h0, a} & m);
      OP_MTLO: lo = 32'({32'h0, a} & m);
      default: ;
    endcase
  endfunction

  // Compare process: every cycle, busy/done/results/held HI-LO against the model queue.
  always @(negedge clk) begin : cmp
    int   i;
    bit   pend;
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      if (!rst_n) begin
        chi[s] = '0;
        clo[s] = '0;
        rd[s]  = q.size();
      end else begin
        i = rd[s];
        while (i < q.size() && (q[i].sel != s || cyc >= q[i].cancel)) i++;
        rd[s] = i;
        pend  = i < q.size();
        e     = pend ? q[i] : '{default: 0};
        check("busy", {31'h0, get_busy(s)},
              {31'h0, pend && e.multi && cyc >= e.acc && cyc < e.due});
        if (get_done(s)) begin
          if (pend && e.due == cyc) begin
            check("res_hi", get_hi(s), e.hi);
            check("res_lo", get_lo(s), e.lo);
            check("res_dbz", {31'h0, get_dbz(s)}, {31'h0, e.dbz});
            chi[s] = e.hi;
            clo[s] = e.lo;
            rd[s]  = i + 1;
          end else begin
            check("unexpected_done", 32'd1, 32'd0);
          end
        end else begin
          if (pend && cyc >= e.due) begin
            check("missing_done", 32'd0, 32'd1);
            rd[s] = i + 1;
          end
          check("hold_hi", get_hi(s), chi[s]);
          check("hold_lo", get_lo(s), clo[s]);
          check("dbz_idle", {31'h0, get_dbz(s)}, 32'd0);
        end
      end
    end
  end

  task automatic drive(input int s, input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (s == 0) begin
      bus32.start = st; bus32.op = op; bus32.a = a; bus32.b = b;
    end else begin
      bus8.start = st; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0];
    end
  endtask

  task automatic set_flush(input int s, input logic f);
    if (s == 0) bus32.flush = f;
    else bus8.flush = f;
  endtask

  // Called at a negedge; returns at the first negedge after the accept edge.
  task automatic issue(input int s, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int idx);
    exp_t        e;
    logic [31:0] m, nh, nl;
    logic        nd;
    int          lat;
    m = (s == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    drive(s, 1'b1, op, a, b);
    model((s == 0) ? 32 : 8, op, a & m, b & m, pred_hi[s], pred_lo[s], nh, nl, nd, lat);
    e.sel     = s;
    e.acc     = cyc + 1;
    e.due     = e.acc + lat - 1;
    e.cancel  = NEVER;
    e.multi   = lat > 1;
    e.hi      = nh;
    e.lo      = nl;
    e.dbz     = nd;
    e.prev_hi = pred_hi[s];
    e.prev_lo = pred_lo[s];
    pred_hi[s] = nh;
    pred_lo[s] = nl;
    q.push_back(e);
    idx = q.size() - 1;
    @(negedge clk);
    drive(s, 1'b0, 3'($urandom), $urandom, $urandom);
  endtask

  task automatic do_op(input int s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rhi, output logic [31:0] rlo, output logic rdbz,
                       output int lat);
    int idx;
    issue(s, op, a, b, idx);
    lat = 1;
    while (!get_done(s) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!get_done(s)) check("done_timeout", 32'd0, 32'd1);
    rhi  = get_hi(s);
    rlo  = get_lo(s);
    rdbz = get_dbz(s);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'h0000_0080;
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] h, l;
    logic        z;
    int          lat, idx;
    for (int s = 0; s < 2; s++) begin
      drive(s, 1'b0, 3'd0, 32'd0, 32'd0);
      set_flush(s, 1'b0);
      pred_hi[s] = '0;
      pred_lo[s] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_hi", get_hi(s), 32'h0);
      check("rst_lo", get_lo(s), 32'h0);
      check("rst_busy", {31'h0, get_busy(s)}, 32'h0);
      check("rst_done", {31'h0, get_done(s)}, 32'h0);
      check("rst_dbz", {31'h0, get_dbz(s)}, 32'h0);
    end

    // W=32 directed values
    do_op(0, OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, h, l, z, lat);
    check("mult_lat", 32'(lat), 32'd34);
    check("mult_hi", h, 32'hFFFF_FFFF);
    check("mult_lo", l, 32'hFFFF_FFF1);
    do_op(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, z, lat);
    check("multu_hi", h, 32'hFFFF_FFFE);
    check("multu_lo", l, 32'h0000_0001);
    do_op(0, OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, z, lat);
    check("mult_m1_hi", h, 32'h0000_0000);
    check("mult_m1_lo", l, 32'h0000_0001);
    do_op(0, OP_DIVU, 32'd100, 32'd7, h, l, z, lat);
    check("divu_lo", l, 32'h0000_000E);
    check("divu_hi", h, 32'h0000_0002);
    do_op(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, h, l, z, lat);
    check("div_neg_lo", l, 32'hFFFF_FFFD);
    check("div_neg_hi", h, 32'hFFFF_FFFF);
    do_op(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, h, l, z, lat);
    check("div_ovf_lo", l, 32'h8000_0000);
    check("div_ovf_hi", h, 32'h0000_0000);
    do_op(0, OP_MTHI, 32'h1234_5678, 32'h0, h, l, z, lat);
    check("mthi_hi", h, 32'h1234_5678);
    do_op(0, OP_DIV, 32'h0000_0055, 32'h0, h, l, z, lat);
    check("dbz_lat", 32'(lat), 32'd1);
    check("dbz_flag", {31'h0, z}, 32'd1);
    check("dbz_hi", h, 32'h1234_5678);
    check("dbz_lo", l, 32'h8000_0000);

    // Ignored start while busy, then flush mid-multiply
    issue(0, OP_MULT, 32'd7, 32'd9, idx);
    repeat (4) @(negedge clk);
    drive(0, 1'b1, OP_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    drive(0, 1'b0, OP_MULTU, 32'd0, 32'd0);
    repeat (4) @(negedge clk);
    q[idx].cancel = cyc + 1;
    pred_hi[0] = q[idx].prev_hi;
    pred_lo[0] = q[idx].prev_lo;
    set_flush(0, 1'b1);
    @(negedge clk);
    set_flush(0, 1'b0);
    check("flush_busy", {31'h0, get_busy(0)}, 32'd0);
    check("flush_done", {31'h0, get_done(0)}, 32'd0);
    check("flush_hi", get_hi(0), 32'h1234_5678);
    check("flush_lo", get_lo(0), 32'h8000_0000);
    repeat (40) @(negedge clk);
    do_op(0, OP_MTLO, 32'hDEAD_BEEF, 32'h0, h, l, z, lat);
    check("mtlo_lo", l, 32'hDEAD_BEEF);
    check("mtlo_hi", h, 32'h1234_5678);

    // Asynchronous reset in the middle of a divide
    issue(0, OP_DIV, 32'd1000, 32'hFFFF_FFFD, idx);
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hi", get_hi(0), 32'h0);
    check("arst_lo", get_lo(0), 32'h0);
    check("arst_busy", {31'h0, get_busy(0)}, 32'h0);
    check("arst_done", {31'h0, get_done(0)}, 32'h0);
    for (int s = 0; s < 2; s++) begin
      pred_hi[s] = '0;
      pred_lo[s] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(0, OP_DIVU, 32'd9, 32'd3, h, l, z, lat);
    check("post_rst_lo", l, 32'h3);
    check("post_rst_hi", h, 32'h0);

    // W=8 directed values
    do_op(1, OP_MULT, 32'hFD, 32'h05, h, l, z, lat);
    check("w8_mult_lat", 32'(lat), 32'd10);
    check("w8_mult_hi", h, 32'hFF);
    check("w8_mult_lo", l, 32'hF1);
    do_op(1, OP_MULTU, 32'hFF, 32'hFF, h, l, z, lat);
    check("w8_multu_hi", h, 32'hFE);
    check("w8_multu_lo", l, 32'h01);
    do_op(1, OP_DIVU, 32'd100, 32'd7, h, l, z, lat);
    check("w8_divu_lo", l, 32'h0E);
    check("w8_divu_hi", h, 32'h02);
    do_op(1, OP_DIV, 32'hF9, 32'h02, h, l, z, lat);
    check("w8_div_lo", l, 32'hFD);
    check("w8_div_hi", h, 32'hFF);
    do_op(1, OP_DIV, 32'h80, 32'hFF, h, l, z, lat);
    check("w8_ovf_lo", l, 32'h80);
    check("w8_ovf_hi", h, 32'h00);

    // Randomized traffic on both widths, back-to-back through DONE
    for (int n = 0; n < 200; n++) begin
      do_op(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pick(), pick(), h, l, z, lat);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit with architectural HI/LO registers.
- Serves the MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO instructions and feeds MFHI/MFLO.
- Sits beside the combinational ALU in the datapath; the controller stalls on busy.
- Iterative radix-2 design: one bit per cycle, with start/busy/done handshake and flush.

Parameters:
- W, 32: operand width; must be even and ≥4. HI and LO are each W bits.
- CW, $clog2(W)+1: iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when busy=0
- op  in  3  0=MULTU, 1=MULT, 2=DIVU, 3=DIV, 4=MTHI, 5=MTLO, 6/7 reserved
- a  in  W  multiplicand / dividend / MTHI-MTLO source
- b  in  W  multiplier / divisor
- flush  in  1  abort in-flight operation
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- div_by_zero  out  1  valid with done; set when a DIV/DIVU divisor was 0
- hi  out  W  HI register
- lo  out  W  LO register

Behaviour:
- Reset (async, rst_n=0):
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0; FSM returns to IDLE.
  - Reset mid-operation discards all partial state.
- States: IDLE, MUL, DIV, FIX, DONE.
- Acceptance: start=1 and busy=0 at a rising edge. Operands and op are latched; a and b may change afterwards. start while busy=1 is ignored.
- MULT/MULTU:
  - IDLE -> MUL for W cycles, shift-add on magnitudes (signed ops take absolute values; sign = a[W-1]^b[W-1]).
  - MUL -> FIX for 1 cycle: negate the 2W product if sign=1.
  - FIX -> DONE.
- DIV/DIVU:
  - IDLE -> DIV for W cycles, restoring division on magnitudes.
  - DIV -> FIX: quotient negated when operand signs differ; remainder takes the dividend's sign.
  - FIX -> DONE.
- Latency: busy=1 from the edge after acceptance through FIX. In DONE, busy=0 and done=1 for exactly one cycle, and hi/lo are updated on the edge entering DONE. Accept edge to done is W+2 cycles. DONE -> IDLE unconditionally; a start during DONE is accepted (busy=0).
- Result mapping:
  - Multiply: hi = product[2W-1:W], lo = product[W-1:0].
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (b==0):
  - No iteration; IDLE -> DONE next cycle, done=1, div_by_zero=1, hi/lo unchanged.
  - div_by_zero is otherwise 0 and is cleared when leaving DONE.
- Signed overflow: DIV of MIN by -1 gives lo=MIN, hi=0 (natural truncation of the magnitude result; no flag).
- MTHI/MTLO:
  - hi (or lo) <= a on the accept edge; no busy.
  - IDLE -> DONE, done=1 next cycle.
- Reserved ops: accepted, no register change, done pulses next cycle.
- flush=1 at any edge: FSM -> IDLE, busy=0, done=0, hi/lo keep pre-operation values; overrides start on the same edge.
- Partial product/remainder registers never drive hi/lo before DONE.
- Counter:
  - Loads W on entry to MUL/DIV and decrements each cycle.
  - Exit when the counter reaches 1 on the edge it would hit 0.
  - No wrap-around is reachable.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings (OP_MULTU..OP_MTLO);
  - the state enumeration (IDLE, MUL, DIV, FIX, DONE);
  - localparam W_DEFAULT=32.
- One natural sub-module, muldiv_core: combinational one-iteration step.
  - Multiply: conditional add + shift.
  - Divide: trial subtract + shift.
  - Instantiated once and shared by MUL and DIV states.
- The FSM, counter, sign fix-up and HI/LO registers stay in muldiv_unit.

Test Plan:
- W=32, MULT a=FFFFFFFD (-3), b=00000005 -> done 34 cycles after accept; hi=FFFFFFFF, lo=FFFFFFF1.
- MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Then MULT with the same operands -> hi=00000000, lo=00000001.
- DIVU a=100, b=7 -> lo=0000000E, hi=00000002. DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
- DIV with b=0 after MTHI a=12345678 -> done one cycle after accept, div_by_zero=1, hi=12345678, lo unchanged.
- Start a MULT; pulse start with a new op at cycle 5 -> ignored. flush at cycle 10 -> busy=0, no done, hi/lo unchanged. A subsequent MTLO a=DEADBEEF -> lo=DEADBEEF.
- rst_n low mid-DIV (cycle 12) -> hi=lo=0, busy=done=0 immediately (asynchronous). After release, DIVU 9/3 -> lo=3, hi=0.
- Repeat the multiply/divide checks at W=8 (e.g. MULT 0xFD*0x05 -> hi=FF, lo=F1) with latency 10.
